// File: rtl/addsub_pkg.sv
// Shared types for the add/sub command issuer: buffered command record and issuer FSM states.
package addsub_pkg;

    localparam int ADDSUB_DATA_WIDTH = 4;
    localparam int ADDSUB_CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } issuer_state_t;

    typedef struct packed {
        logic                         op;
        logic [ADDSUB_DATA_WIDTH-1:0] data1;
        logic [ADDSUB_DATA_WIDTH-1:0] data2;
    } addsub_cmd_t;

endpackage

// File: rtl/addsub_cmd_issuer_if.sv
// Command/issue bus of the add/sub issuer; issue_cnt exists only when ADDSUB_ISSUE_CNT_EN is defined.
interface addsub_cmd_issuer_if #(
    parameter int DATA_WIDTH = 4,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_op;
    logic [DATA_WIDTH-1:0] cmd_data1;
    logic [DATA_WIDTH-1:0] cmd_data2;
    logic                  hold_in;
    logic                  flush_in;
    logic                  issue_en;
    logic                  issue_control;
    logic [DATA_WIDTH-1:0] issue_data1;
    logic [DATA_WIDTH-1:0] issue_data2;
    logic [CNT_W-1:0]      fifo_count;

`ifdef ADDSUB_ISSUE_CNT_EN
    logic [15:0]           issue_cnt;

    modport master (
        output cmd_valid, cmd_op, cmd_data1, cmd_data2, hold_in, flush_in,
        input  cmd_ready, issue_en, issue_control, issue_data1, issue_data2, fifo_count, issue_cnt
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_data1, cmd_data2, hold_in, flush_in,
        output cmd_ready, issue_en, issue_control, issue_data1, issue_data2, fifo_count, issue_cnt
    );
`else
    modport master (
        output cmd_valid, cmd_op, cmd_data1, cmd_data2, hold_in, flush_in,
        input  cmd_ready, issue_en, issue_control, issue_data1, issue_data2, fifo_count
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_data1, cmd_data2, hold_in, flush_in,
        output cmd_ready, issue_en, issue_control, issue_data1, issue_data2, fifo_count
    );
`endif

endinterface

// File: rtl/addsub_cmd_fifo.sv
// Circular command buffer: storage array, wrapping read/write pointers and occupancy count.
module addsub_cmd_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap to 0 by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_data = mem[rd_ptr_reg];
    assign count     = count_reg;
    assign full      = (count_reg == CNT_W'(DEPTH));
    assign empty     = (count_reg == '0);

endmodule

// File: rtl/addsub_cmd_issuer.sv
// Buffers add/sub commands and issues one per cycle to the add/sub stage with registered outputs.
// Define ADDSUB_ISSUE_CNT_EN to add the 16-bit issue_cnt output.
module addsub_cmd_issuer
    import addsub_pkg::*;
#(
    parameter int DATA_WIDTH = ADDSUB_DATA_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    addsub_cmd_issuer_if.slave bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CMD_W = 1 + 2 * DATA_WIDTH;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [CMD_W-1:0]      head_data;
    logic                  cmd_ready;
    logic                  push;
    logic                  pop;
    logic [CNT_W-1:0]      count_after;

    issuer_state_t         state_reg;
    logic                  issue_en_reg;
    logic                  issue_control_reg;
    logic [DATA_WIDTH-1:0] issue_data1_reg;
    logic [DATA_WIDTH-1:0] issue_data2_reg;

    assign cmd_ready = !fifo_full && !bus.flush_in && !rst;
    assign push      = bus.cmd_valid && cmd_ready;
    // IDLE implies an empty buffer, so a command pushed at an edge pops on the very next edge.
    assign pop       = (state_reg != IDLE) && !fifo_empty && !bus.hold_in && !bus.flush_in;

    addsub_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.flush_in),
        .push      (push),
        .push_data ({bus.cmd_op, bus.cmd_data1, bus.cmd_data2}),
        .pop       (pop),
        .head_data (head_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        count_after = fifo_count;
        if (push && !pop) begin
            count_after = fifo_count + CNT_W'(1);
        end else if (pop && !push) begin
            count_after = fifo_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else if (bus.flush_in) begin
            state_reg <= IDLE;
        end else if (bus.hold_in) begin
            state_reg <= HOLD;
        end else if (count_after != '0) begin
            state_reg <= ISSUE;
        end else begin
            state_reg <= IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_en_reg      <= 1'b0;
            issue_control_reg <= 1'b0;
            issue_data1_reg   <= '0;
            issue_data2_reg   <= '0;
        end else begin
            issue_en_reg <= pop;
            if (pop) begin
                {issue_control_reg, issue_data1_reg, issue_data2_reg} <= head_data;
            end
        end
    end

`ifdef ADDSUB_ISSUE_CNT_EN
    logic [ADDSUB_CNT_WIDTH-1:0] issue_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt_reg <= '0;
        end else if (bus.flush_in) begin
            issue_cnt_reg <= '0;
        end else if (issue_en_reg) begin
            issue_cnt_reg <= issue_cnt_reg + ADDSUB_CNT_WIDTH'(1);
        end
    end

    assign bus.issue_cnt = issue_cnt_reg;
`endif

    assign bus.cmd_ready     = cmd_ready;
    assign bus.issue_en      = issue_en_reg;
    assign bus.issue_control = issue_control_reg;
    assign bus.issue_data1   = issue_data1_reg;
    assign bus.issue_data2   = issue_data2_reg;
    assign bus.fifo_count    = fifo_count;

endmodule

// File: tb/tb_addsub_cmd_issuer.sv
// Directed bench for addsub_cmd_issuer; the issue_cnt scenario runs only with ADDSUB_ISSUE_CNT_EN.
module tb_addsub_cmd_issuer;
    import addsub_pkg::*;

    localparam int DW = 4;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    addsub_cmd_issuer_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) bus ();

    addsub_cmd_issuer #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic v, input addsub_cmd_t c);
        bus.cmd_valid = v;
        bus.cmd_op    = c.op;
        bus.cmd_data1 = c.data1;
        bus.cmd_data2 = c.data2;
    endtask

    task automatic idle_inputs();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 1'b0;
        bus.cmd_data1 = '0;
        bus.cmd_data2 = '0;
        bus.hold_in   = 1'b0;
        bus.flush_in  = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus.issue_en !== 1'b0) begin n_bad++; $display("FAIL reset_en: got %b want 0", bus.issue_en); end
        n_cmp++; if (bus.issue_control !== 1'b0) begin n_bad++; $display("FAIL reset_ctrl: got %b want 0", bus.issue_control); end
        n_cmp++; if ({bus.issue_data1, bus.issue_data2} !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", {bus.issue_data1, bus.issue_data2}); end
        n_cmp++; if (bus.fifo_count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", bus.fifo_count); end
        tick();
        tick();
        n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready_low: got %b want 0", bus.cmd_ready); end
`ifdef ADDSUB_ISSUE_CNT_EN
        n_cmp++; if (bus.issue_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", bus.issue_cnt); end
`endif
        rst = 1'b0;
        tick();
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_high: got %b want 1", bus.cmd_ready); end
        $display("reset done");
    endtask

    task automatic test_single_push();
        addsub_cmd_t c;
        addsub_cmd_t got;
        logic [DW:0] y;
        c = {1'b1, 4'd3, 4'd5};
        idle_inputs();
        drive_cmd(1'b1, c);
        tick();
        bus.cmd_valid = 1'b0;
        n_cmp++; if (bus.issue_en !== 1'b0) begin n_bad++; $display("FAIL single_early_en: got %b want 0", bus.issue_en); end
        n_cmp++; if (bus.fifo_count !== 3'd1) begin n_bad++; $display("FAIL single_count: got %0d want 1", bus.fifo_count); end
        tick();
        got = {bus.issue_control, bus.issue_data1, bus.issue_data2};
        y = {1'b0, bus.issue_data1} + {1'b0, bus.issue_data2};
        $display("issue op=%0d a=%0d b=%0d y=%0d", got.op, got.data1, got.data2, y);
        n_cmp++; if (bus.issue_en !== 1'b1) begin n_bad++; $display("FAIL single_en: got %b want 1", bus.issue_en); end
        n_cmp++; if (got !== c) begin n_bad++; $display("FAIL single_cmd: got %h want %h", got, c); end
        n_cmp++; if (y !== 5'd8) begin n_bad++; $display("FAIL single_y: got %0d want 8", y); end
        n_cmp++; if (bus.fifo_count !== 3'd0) begin n_bad++; $display("FAIL single_drain: got %0d want 0", bus.fifo_count); end
        tick();
        got = {bus.issue_control, bus.issue_data1, bus.issue_data2};
        n_cmp++; if (bus.issue_en !== 1'b0) begin n_bad++; $display("FAIL single_en_off: got %b want 0", bus.issue_en); end
        n_cmp++; if (got !== c) begin n_bad++; $display("FAIL single_hold_val: got %h want %h", got, c); end
    endtask

    task automatic test_back_to_back();
        addsub_cmd_t exp [5];
        addsub_cmd_t got;
        exp[0] = {1'b1, 4'd1,  4'd2};
        exp[1] = {1'b0, 4'd9,  4'd4};
        exp[2] = {1'b1, 4'd15, 4'd15};
        exp[3] = {1'b0, 4'd0,  4'd1};
        exp[4] = {1'b1, 4'd7,  4'd8};
        idle_inputs();
        bus.hold_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_fill_ready[%0d]: got %b want 1", i, bus.cmd_ready); end
            drive_cmd(1'b1, exp[i]);
            tick();
        end
        drive_cmd(1'b1, exp[4]);
        bus.hold_in = 1'b0;
        n_cmp++; if (bus.fifo_count !== 3'd4) begin n_bad++; $display("FAIL b2b_full_count: got %0d want 4", bus.fifo_count); end
        n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_full_ready: got %b want 0", bus.cmd_ready); end
        n_cmp++; if (bus.issue_en !== 1'b0) begin n_bad++; $display("FAIL b2b_hold_en: got %b want 0", bus.issue_en); end
        tick();
        n_cmp++; if (bus.fifo_count !== 3'd3) begin n_bad++; $display("FAIL b2b_after_pop_count: got %0d want 3", bus.fifo_count); end
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_reopen: got %b want 1", bus.cmd_ready); end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                tick();
            end
            if (i == 1) begin
                bus.cmd_valid = 1'b0;
                n_cmp++; if (bus.fifo_count !== 3'd3) begin n_bad++; $display("FAIL b2b_pushpop_count: got %0d want 3", bus.fifo_count); end
            end
            got = {bus.issue_control, bus.issue_data1, bus.issue_data2};
            $display("issue op=%0d a=%0d b=%0d", got.op, got.data1, got.data2);
            n_cmp++; if (bus.issue_en !== 1'b1) begin n_bad++; $display("FAIL b2b_en[%0d]: got %b want 1", i, bus.issue_en); end
            n_cmp++; if (got !== exp[i]) begin n_bad++; $display("FAIL b2b_order[%0d]: got %h want %h", i, got, exp[i]); end
        end
        tick();
        n_cmp++; if (bus.issue_en !== 1'b0) begin n_bad++; $display("FAIL b2b_end_en: got %b want 0", bus.issue_en); end
        n_cmp++; if (bus.fifo_count !== 3'd0) begin n_bad++; $display("FAIL b2b_end_count: got %0d want 0", bus.fifo_count); end
    endtask

    task automatic test_hold();
        addsub_cmd_t exp [2];
        addsub_cmd_t got;
        exp[0] = {1'b1, 4'd6, 4'd2};
        exp[1] = {1'b0, 4'd5, 4'd3};
        idle_inputs();
        bus.hold_in = 1'b1;
        drive_cmd(1'b1, exp[0]);
        tick();
        drive_cmd(1'b1, exp[1]);
        tick();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (bus.issue_en !== 1'b0) begin n_bad++; $display("FAIL hold_en[%0d]: got %b want 0", i, bus.issue_en); end
            n_cmp++; if (bus.fifo_count !== 3'd2) begin n_bad++; $display("FAIL hold_count[%0d]: got %0d want 2", i, bus.fifo_count); end
            tick();
        end
        bus.hold_in = 1'b0;
        n_cmp++; if (bus.issue_en !== 1'b0) begin n_bad++; $display("FAIL hold_release_en: got %b want 0", bus.issue_en); end
        for (int i = 0; i < 2; i++) begin
            tick();
            got = {bus.issue_control, bus.issue_data1, bus.issue_data2};
            $display("issue op=%0d a=%0d b=%0d", got.op, got.data1, got.data2);
            n_cmp++; if (bus.issue_en !== 1'b1) begin n_bad++; $display("FAIL hold_issue_en[%0d]: got %b want 1", i, bus.issue_en); end
            n_cmp++; if (got !== exp[i]) begin n_bad++; $display("FAIL hold_issue[%0d]: got %h want %h", i, got, exp[i]); end
        end
        tick();
        n_cmp++; if (bus.issue_en !== 1'b0) begin n_bad++; $display("FAIL hold_end_en: got %b want 0", bus.issue_en); end
    endtask

    task automatic test_flush();
        addsub_cmd_t p [4];
        p[0] = {1'b1, 4'd1,  4'd1};
        p[1] = {1'b0, 4'd2,  4'd2};
        p[2] = {1'b1, 4'd3,  4'd3};
        p[3] = {1'b0, 4'd15, 4'd1};
        idle_inputs();
        bus.hold_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_cmd(1'b1, p[i]);
            tick();
        end
        drive_cmd(1'b1, p[3]);
        bus.flush_in = 1'b1;
        #1;
        n_cmp++; if (bus.fifo_count !== 3'd3) begin n_bad++; $display("FAIL flush_pre_count: got %0d want 3", bus.fifo_count); end
        n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready: got %b want 0", bus.cmd_ready); end
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (bus.fifo_count !== 3'd0) begin n_bad++; $display("FAIL flush_count: got %0d want 0", bus.fifo_count); end
        n_cmp++; if (bus.issue_en !== 1'b0) begin n_bad++; $display("FAIL flush_en: got %b want 0", bus.issue_en); end
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL flush_ready_after: got %b want 1", bus.cmd_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (bus.issue_en !== 1'b0) begin n_bad++; $display("FAIL flush_quiet_en[%0d]: got %b want 0", i, bus.issue_en); end
            n_cmp++; if (bus.fifo_count !== 3'd0) begin n_bad++; $display("FAIL flush_quiet_count[%0d]: got %0d want 0", i, bus.fifo_count); end
        end
        $display("flush done");
    endtask

    task automatic test_reset_mid();
        addsub_cmd_t r0;
        addsub_cmd_t r1;
        addsub_cmd_t got;
        r0 = {1'b0, 4'd2, 4'd7};
        r1 = {1'b1, 4'd1, 4'd1};
        idle_inputs();
        bus.hold_in = 1'b1;
        drive_cmd(1'b1, r0);
        tick();
        drive_cmd(1'b1, r1);
        tick();
        idle_inputs();
        tick();
        got = {bus.issue_control, bus.issue_data1, bus.issue_data2};
        $display("issue op=%0d a=%0d b=%0d", got.op, got.data1, got.data2);
        n_cmp++; if (bus.issue_en !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_en: got %b want 1", bus.issue_en); end
        n_cmp++; if (got !== r0) begin n_bad++; $display("FAIL rstmid_pre_cmd: got %h want %h", got, r0); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus.issue_en !== 1'b0) begin n_bad++; $display("FAIL rstmid_en: got %b want 0", bus.issue_en); end
        n_cmp++; if (bus.issue_control !== 1'b0) begin n_bad++; $display("FAIL rstmid_ctrl: got %b want 0", bus.issue_control); end
        n_cmp++; if ({bus.issue_data1, bus.issue_data2} !== 8'h00) begin n_bad++; $display("FAIL rstmid_data: got %h want 00", {bus.issue_data1, bus.issue_data2}); end
        n_cmp++; if (bus.fifo_count !== 3'd0) begin n_bad++; $display("FAIL rstmid_count: got %0d want 0", bus.fifo_count); end
        n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_ready: got %b want 0", bus.cmd_ready); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (bus.issue_en !== 1'b0) begin n_bad++; $display("FAIL rstmid_quiet_en[%0d]: got %b want 0", i, bus.issue_en); end
            n_cmp++; if (bus.fifo_count !== 3'd0) begin n_bad++; $display("FAIL rstmid_quiet_count[%0d]: got %0d want 0", i, bus.fifo_count); end
        end
        $display("mid-burst reset done");
    endtask

`ifdef ADDSUB_ISSUE_CNT_EN
    task automatic test_issue_cnt();
        addsub_cmd_t c;
        idle_inputs();
        bus.flush_in = 1'b1;
        tick();
        bus.flush_in = 1'b0;
        n_cmp++; if (bus.issue_cnt !== 16'd0) begin n_bad++; $display("FAIL cnt_flush: got %0d want 0", bus.issue_cnt); end
        for (int i = 0; i < 10; i++) begin
            c = {i[0], i[3:0], 4'd1};
            drive_cmd(1'b1, c);
            tick();
        end
        idle_inputs();
        repeat (4) tick();
        n_cmp++; if (bus.issue_cnt !== 16'd10) begin n_bad++; $display("FAIL cnt_ten: got %0d want 10", bus.issue_cnt); end
        c = {1'b1, 4'd2, 4'd3};
        drive_cmd(1'b1, c);
        repeat (65525) tick();
        idle_inputs();
        repeat (4) tick();
        n_cmp++; if (bus.issue_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL cnt_max: got %h want ffff", bus.issue_cnt); end
        drive_cmd(1'b1, c);
        tick();
        idle_inputs();
        repeat (4) tick();
        n_cmp++; if (bus.issue_cnt !== 16'd0) begin n_bad++; $display("FAIL cnt_wrap: got %h want 0000", bus.issue_cnt); end
        $display("issue counter done");
    endtask
`endif

    initial begin
        test_reset();
        test_single_push();
        test_back_to_back();
        test_hold();
        test_flush();
        test_reset_mid();
`ifdef ADDSUB_ISSUE_CNT_EN
        test_issue_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
